// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and a small receive FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 6,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       clr_err,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic          parity_set;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [NW-1:0] count, count_nxt, count_after_pop;
  logic          pop, full, do_push, ovr_set;
  logic [7:0]    head_nxt;

  // Two-flop synchronizer; the extra flop gives the previous sample for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt    = '0;
          parity_set = ^{shreg, rx_s};
          state_nxt  = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            push_req  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO control; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop             = rx_valid && rx_ready;
    full            = (count == NW'(FIFO_DEPTH));
    do_push         = push_req && (!full || pop);
    ovr_set         = push_req && full && !pop;
    count_after_pop = count - NW'(pop);
    count_nxt       = count_after_pop + NW'(do_push);
    rd_ptr_nxt      = rd_ptr + AW'(pop);
    if (count_nxt == '0) begin
      head_nxt = 8'h00;
    end else if (do_push && count_after_pop == '0) begin
      head_nxt = shreg;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      wr_ptr   <= wr_ptr + AW'(do_push);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rx_valid <= (count_nxt != '0);
      rx_data  <= head_nxt;
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= frame_set | (frame_err & ~clr_err);
      overrun    <= ovr_set | (overrun & ~clr_err);
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_set | (parity_err & ~clr_err);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo at CLKS_PER_BIT=6, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 6;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, rx, rx_ready, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .clr_err   (clr_err),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_head;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; entered and left 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_cycles);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    tick(stop_cycles);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(rx_valid), 32'd1);
    check({name, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, CPB);
      check($sformatf("row%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d_head", i), 32'(rx_data), 32'(vecs[i].exp_head));
      check($sformatf("row%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("row%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back burst, then the overrun burst into an empty 4-deep FIFO.
    vecs[0] = '{8'h31, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[1] = '{8'h30, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[2] = '{8'h64, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[3] = '{8'h30, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[4] = '{8'h30, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{8'h31, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{8'h32, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{8'h33, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[8] = '{8'h34, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1};

    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
    tick(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single frame: rx_valid rises exactly one clock after the stop sample.
    send_frame(8'h31, 1'b1, CPB - 1);
    check("lat_early_valid", 32'(rx_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    tick(1);
    check("lat_valid", 32'(rx_valid), 32'd1);
    check("lat_data", 32'(rx_data), 32'h31);
    check("lat_ferr", 32'(frame_err), 32'd0);
    tick(3);
    pop_expect("single_pop", 8'h31);
    check("single_empty", 32'(rx_valid), 32'd0);

    apply_rows(0, 3);
    pop_expect("b2b_pop0", 8'h31);
    pop_expect("b2b_pop1", 8'h30);
    pop_expect("b2b_pop2", 8'h64);
    pop_expect("b2b_pop3", 8'h30);
    check("b2b_empty", 32'(rx_valid), 32'd0);

    apply_rows(4, 8);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    pop_expect("ovr_pop0", 8'h30);
    pop_expect("ovr_pop1", 8'h31);
    pop_expect("ovr_pop2", 8'h32);
    pop_expect("ovr_pop3", 8'h33);
    check("ovr_empty", 32'(rx_valid), 32'd0);

    // Low stop bit followed by a 20-bit break.
    send_frame(8'h52, 1'b0, CPB);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_nopush", 32'(rx_valid), 32'd0);
    check("ferr_busy", 32'(busy), 32'd1);
    tick(19 * CPB);
    check("break_busy", 32'(busy), 32'd1);
    check("break_nopush", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    tick(4);
    check("break_idle", 32'(busy), 32'd0);
    tick(CPB);
    send_frame(8'h0A, 1'b1, CPB);
    check("after_break_valid", 32'(rx_valid), 32'd1);
    check("after_break_data", 32'(rx_data), 32'h0A);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    pop_expect("after_break_pop", 8'h0A);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Two-cycle glitch on an idle line.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(2);
    check("glitch_busy", 32'(busy), 32'd1);
    tick(3 * CPB);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_nopush", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_ovr", 32'(overrun), 32'd0);

    // Reset asserted during bit 3 of a frame, with one byte already buffered.
    send_frame(8'h33, 1'b1, CPB);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h35 >> i);
      tick(CPB);
    end
    rx = 1'(8'h35 >> 3);
    tick(3);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    tick(2);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(3 * CPB);
    send_frame(8'h35, 1'b1, CPB);
    check("post_rst_ferr", 32'(frame_err), 32'd0);
    pop_expect("post_rst_pop", 8'h35);
    check("post_rst_empty", 32'(rx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the SOC serial input. Mirrors the bench-side transmitter: 8N1 framing, LSB first, line idles high, fixed clocks-per-bit timing.
- Samples each bit at mid-bit, checks the stop bit, and buffers received bytes in a small FIFO.
- The CPU drains bytes through a valid/ready pop interface.
- Sticky framing-error and overrun flags are exposed for the status register.

Parameters:
- CLKS_PER_BIT, 6, clk cycles per serial bit; must be >= 4; counter width is clog2(CLKS_PER_BIT).
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer pop; pop occurs on a cycle where rx_valid&&rx_ready
- clr_err  input  1  clears frame_err and overrun
- frame_err  output  1  sticky: stop bit sampled 0
- overrun  output  1  sticky: byte dropped because FIFO was full
- busy  output  1  high while FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; bit and clock counters cleared.
  - FIFO empty; rx_valid=0, rx_data=0.
  - frame_err=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1.
- Synchronizer:
  - rx passes through 2 flops, giving rx_s; all logic uses rx_s only.
  - Edge detect uses the previous rx_s.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: a 1->0 transition of rx_s loads cnt=0 and moves to START.
  - START: when cnt reaches CLKS_PER_BIT/2-1, sample rx_s.
    - 0: move to DATA with cnt=0, bit=0.
    - 1: glitch; return to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into shreg[7] (right shift, LSB first). After bit 7, move to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: push shreg and return to IDLE.
    - 0: set frame_err, discard the byte, move to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE (a break condition does not retrigger).
- FIFO push:
  - Occurs on the stop-sample cycle.
  - If full and no pop that cycle: drop the byte, set overrun, leave FIFO contents unchanged.
  - If full with a simultaneous pop: accept the push.
- FIFO pop:
  - rx_data is the registered head entry.
  - After a pop, the next entry appears the following cycle.
  - A pop while empty is ignored.
- Latency: rx_valid rises 1 clk after the stop-sample cycle when the FIFO was empty.
- Pointers: wrap modulo FIFO_DEPTH; a count register of clog2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Error flags: clr_err clears both flags next cycle. If an error event coincides with clr_err, the set wins.
- busy: equals (state != IDLE).
- Reset mid-frame: the partial byte is lost. After release, the FSM waits in IDLE for the next falling edge; the remainder of a frame in flight may be misread as a new start, and that is acceptable.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting one bit time.
  - Checks even parity (XOR of 8 data bits and the parity bit must be 0).
  - Adds output parity_err (sticky, cleared by clr_err); a byte with bad parity is still pushed.
- Undefined:
  - Pure 8N1; no PARITY state and no parity_err port.

Test Plan:
- 8N1 frame of 0x31 at CLKS_PER_BIT=6, rx_ready=0 -> rx_valid=1 and rx_data=0x31 starting 1 clk after the stop sample; frame_err=0.
- Back-to-back 0x31,0x30,0x64,0x30, then pop each with rx_ready=1 -> bytes appear in order; rx_valid drops after the 4th pop.
- 5 frames (0x30..0x34) with no pops, FIFO_DEPTH=4 -> FIFO holds 0x30..0x33; overrun=1; 0x34 lost. clr_err pulse -> overrun=0.
- Frame 0x52 with the stop bit forced low, then line held low for 20 bit times -> frame_err=1; no push; busy=1 until rx returns high; next frame 0x0A is received correctly.
- A 2-cycle low glitch on an idle rx -> FSM returns to IDLE; no push; no flags.
- rst_n pulsed low during bit 3 of a frame -> all outputs at reset values immediately; the following clean frame 0x35 is received correctly.
